// File: rtl/mega_mul_seq.sv
// rtl/mega_mul_seq.sv - iterative AVR multiply sequencer (MUL..FMULSU); MEGA_MUL_SEQ_FRAC_EN builds the fractional ops
module mega_mul_seq #(
    parameter int RADIX_BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [7:0]  in_1,
    input  logic [7:0]  in_2,
    output logic        busy,
    output logic        done,
    output logic [15:0] out,
    output logic        ALU_FLAG_C_OUT,
    output logic        ALU_FLAG_Z_OUT,
    output logic        err
);

    localparam int N = 8 / RADIX_BITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [2:0]  cnt;
    logic [2:0]  op_q;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [15:0] a_sh;
    logic [7:0]  b_sh;
    logic [17:0] acc;
    logic [17:0] partial;
    logic        acc_unused;

    logic [15:0] res_q;
    logic        res_c;
    logic        res_z;
    logic        res_err;

    logic        accept;
    logic        run_en;
    logic        fix_en;
    logic        finish;
    logic        last_run;

    logic        legal;
    logic        sgn_a;
    logic        sgn_b;
`ifdef MEGA_MUL_SEQ_FRAC_EN
    logic        frac;
`endif
    logic [15:0] corr_a;
    logic [15:0] corr_b;
    logic [15:0] p_raw;
    logic [15:0] p_fix;

    assign last_run   = (cnt == 3'(N - 1));
    assign acc_unused = ^acc[17:16];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last_run) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        accept = 1'b0;
        run_en = 1'b0;
        fix_en = 1'b0;
        finish = 1'b0;
        case (state)
            S_IDLE:  accept = start;
            S_RUN:   run_en = 1'b1;
            S_FIX:   fix_en = 1'b1;
            S_DONE:  finish = 1'b1;
            default: accept = 1'b0;
        endcase
    end

    // Partial product of this cycle's multiplier digit, built from shifted multiplicand copies.
    always_comb begin
        partial = '0;
        for (int i = 0; i < RADIX_BITS; i++) begin
            if (b_sh[i]) begin
                partial = partial + {2'b00, a_sh << i};
            end
        end
    end

    always_comb begin
        legal = 1'b0;
        sgn_a = 1'b0;
        sgn_b = 1'b0;
`ifdef MEGA_MUL_SEQ_FRAC_EN
        frac  = 1'b0;
`endif
        case (op_q)
            3'd0: legal = 1'b1;
            3'd1: begin legal = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
            3'd2: begin legal = 1'b1; sgn_a = 1'b1; end
`ifdef MEGA_MUL_SEQ_FRAC_EN
            3'd3: begin legal = 1'b1; frac = 1'b1; end
            3'd4: begin legal = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; frac = 1'b1; end
            3'd5: begin legal = 1'b1; sgn_a = 1'b1; frac = 1'b1; end
`endif
            default: legal = 1'b0;
        endcase
    end

    // A negative operand contributes -256 x the other operand (mod 2^16) to the unsigned product.
    always_comb begin
        corr_a = (sgn_a && a_q[7]) ? {b_q, 8'h00} : 16'h0000;
        corr_b = (sgn_b && b_q[7]) ? {a_q, 8'h00} : 16'h0000;
        p_raw  = acc[15:0] - corr_a - corr_b;
`ifdef MEGA_MUL_SEQ_FRAC_EN
        p_fix  = frac ? {p_raw[14:0], 1'b0} : p_raw;
`else
        p_fix  = p_raw;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            op_q           <= '0;
            a_q            <= '0;
            b_q            <= '0;
            a_sh           <= '0;
            b_sh           <= '0;
            acc            <= '0;
            res_q          <= '0;
            res_c          <= 1'b0;
            res_z          <= 1'b0;
            res_err        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            out            <= '0;
            ALU_FLAG_C_OUT <= 1'b0;
            ALU_FLAG_Z_OUT <= 1'b0;
            err            <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                op_q <= op;
                a_q  <= in_1;
                b_q  <= in_2;
                a_sh <= {8'h00, in_1};
                b_sh <= in_2;
                acc  <= '0;
                cnt  <= '0;
                busy <= 1'b1;
                err  <= 1'b0;
            end
            if (run_en) begin
                acc  <= acc + partial;
                a_sh <= a_sh << RADIX_BITS;
                b_sh <= b_sh >> RADIX_BITS;
                cnt  <= cnt + 3'd1;
            end
            if (fix_en) begin
                res_q   <= legal ? p_fix : 16'h0000;
                res_c   <= legal & p_raw[15];
                res_z   <= legal ? (p_fix == 16'h0000) : 1'b1;
                res_err <= ~legal;
            end
            if (finish) begin
                out            <= res_q;
                ALU_FLAG_C_OUT <= res_c;
                ALU_FLAG_Z_OUT <= res_z;
                err            <= res_err;
                done           <= 1'b1;
                busy           <= 1'b0;
            end
        end
    end

endmodule
